// File: rtl/grid_sweep_sequencer.sv
// Raster sequencer: walks every environment cell once per game tick (ADDR/WAIT/WRITE per cell),
// pausable at cell boundaries. Define SWEEP_SERPENTINE_EN for boustrophedon row order.
module grid_sweep_sequencer #(
  parameter int unsigned X_BITS   = 8,
  parameter int unsigned Y_BITS   = 7,
  parameter int unsigned X_MAX    = 159,
  parameter int unsigned Y_MAX    = 119,
  parameter int unsigned READ_LAT = 2
) (
  input  logic              clk,
  input  logic              RESET_SIM_N,
  input  logic              run,
  input  logic              pause,
  input  logic              game_tick,
  output logic [X_BITS-1:0] writeLoc_x,
  output logic [Y_BITS-1:0] writeLoc_y,
  output logic              write_flag,
  output logic              hold_locs,
  output logic              sweep_busy,
  output logic              sweep_done,
  output logic [15:0]       frame_count,
  output logic              overrun
);

  localparam int unsigned CNT_W   = 4;
  localparam int unsigned FRAME_W = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WAIT,
    S_WRITE,
    S_PAUSED
  } state_t;

  state_t              r_state;
  logic [X_BITS-1:0]   r_x;
  logic [Y_BITS-1:0]   r_y;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_pending;
  logic                r_overrun;
  logic [FRAME_W-1:0]  r_frame;
  logic                r_done;
  logic                r_write_flag;
  logic                r_hold;
  logic                r_busy;

  state_t              w_state_nxt;
  logic [X_BITS-1:0]   w_x_nxt;
  logic [Y_BITS-1:0]   w_y_nxt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic                w_pending_nxt;
  logic                w_overrun_nxt;
  logic [FRAME_W-1:0]  w_frame_nxt;
  logic                w_done_nxt;
  logic                w_in_sweep;

  logic                w_row_end;
  logic                w_last_cell;
  logic [X_BITS-1:0]   w_adv_x;
  logic [Y_BITS-1:0]   w_adv_y;

  // Next-cell address and end-of-row / end-of-sweep detection
  always_comb begin
    w_row_end = 1'b0;
    w_adv_x   = r_x;
`ifdef SWEEP_SERPENTINE_EN
    if (r_y[0]) begin
      w_row_end = (r_x == X_BITS'(0));
      w_adv_x   = w_row_end ? r_x : (r_x - X_BITS'(1));
    end else begin
      w_row_end = (r_x == X_BITS'(X_MAX));
      w_adv_x   = w_row_end ? r_x : (r_x + X_BITS'(1));
    end
`else
    w_row_end = (r_x == X_BITS'(X_MAX));
    w_adv_x   = w_row_end ? X_BITS'(0) : (r_x + X_BITS'(1));
`endif
    w_adv_y     = w_row_end ? (r_y + Y_BITS'(1)) : r_y;
    w_last_cell = w_row_end && (r_y == Y_BITS'(Y_MAX));
  end

  // Next-state and datapath updates
  always_comb begin
    w_state_nxt   = r_state;
    w_x_nxt       = r_x;
    w_y_nxt       = r_y;
    w_cnt_nxt     = r_cnt;
    w_pending_nxt = r_pending;
    w_overrun_nxt = r_overrun;
    w_frame_nxt   = r_frame;
    w_done_nxt    = 1'b0;
    w_in_sweep    = (r_state != S_IDLE);

    if (!run) begin
      w_state_nxt   = S_IDLE;
      w_x_nxt       = '0;
      w_y_nxt       = '0;
      w_cnt_nxt     = '0;
      w_pending_nxt = 1'b0;
    end else begin
      // Queue at most one tick behind the running sweep; a second is counted as overrun
      if (game_tick && w_in_sweep) begin
        if (r_pending) w_overrun_nxt = 1'b1;
        else           w_pending_nxt = 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (game_tick || r_pending) begin
            w_state_nxt   = S_ADDR;
            w_x_nxt       = '0;
            w_y_nxt       = '0;
            w_pending_nxt = 1'b0;
          end
        end
        S_ADDR: begin
          w_state_nxt = S_WAIT;
          w_cnt_nxt   = CNT_W'(READ_LAT - 1);
        end
        S_WAIT: begin
          if (r_cnt == '0) w_state_nxt = S_WRITE;
          else             w_cnt_nxt   = r_cnt - CNT_W'(1);
        end
        S_WRITE: begin
          if (w_last_cell) begin
            w_state_nxt = S_IDLE;
            w_x_nxt     = '0;
            w_y_nxt     = '0;
            w_done_nxt  = 1'b1;
            w_frame_nxt = r_frame + FRAME_W'(1);
          end else begin
            w_x_nxt     = w_adv_x;
            w_y_nxt     = w_adv_y;
            w_state_nxt = pause ? S_PAUSED : S_ADDR;
          end
        end
        S_PAUSED: begin
          if (!pause) w_state_nxt = S_ADDR;
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge RESET_SIM_N) begin
    if (!RESET_SIM_N) begin
      r_state      <= S_IDLE;
      r_x          <= '0;
      r_y          <= '0;
      r_cnt        <= '0;
      r_pending    <= 1'b0;
      r_overrun    <= 1'b0;
      r_frame      <= '0;
      r_done       <= 1'b0;
      r_write_flag <= 1'b0;
      r_hold       <= 1'b1;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_x          <= w_x_nxt;
      r_y          <= w_y_nxt;
      r_cnt        <= w_cnt_nxt;
      r_pending    <= w_pending_nxt;
      r_overrun    <= w_overrun_nxt;
      r_frame      <= w_frame_nxt;
      r_done       <= w_done_nxt;
      r_write_flag <= (w_state_nxt == S_WRITE);
      r_hold       <= (w_state_nxt == S_IDLE) || (w_state_nxt == S_PAUSED);
      r_busy       <= (w_state_nxt != S_IDLE);
    end
  end

  assign writeLoc_x  = r_x;
  assign writeLoc_y  = r_y;
  assign write_flag  = r_write_flag;
  assign hold_locs   = r_hold;
  assign sweep_busy  = r_busy;
  assign sweep_done  = r_done;
  assign frame_count = r_frame;
  assign overrun     = r_overrun;

endmodule
